draw_trace: RTL and testbench

DRAW_TRACE -- requirements
Module: draw_trace

---
 rtl/draw_trace_if.sv | 26 ++
 rtl/draw_trace.sv | 212 +++++++++++++++++++++
 tb/tb_draw_trace.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_trace_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_if
// Purpose  : Bundles the VGA timing fields and pixel colour that travel
//            between pixel-pipeline stages.
// Fields   : hcount[10:0], vcount[10:0] - current pixel column / row
//            hsync, vsync               - sync pulses
//            hblnk, vblnk               - horizontal / vertical blanking
//            rgb[11:0]                  - RGB444 pixel colour
// Modports : in  - consumer side (all fields are inputs)
//            out - producer side (all fields are outputs)
// Revision : 1.0 - initial release
// ============================================================================
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_trace.sv
`default_nettype none
// ============================================================================
// Module   : draw_trace
// Purpose  : Oscilloscope-style trace overlay. Captures 512 ADC samples after
//            a rising-edge (or timed-out) trigger into one of two banks and
//            draws the other bank as a one-pixel-high trace inside a
//            512x256 plot window on the VGA stream.
// Ports    : clk          - pixel clock
//            rst          - asynchronous active-high reset
//            sample       - unsigned ADC sample (0 = bottom of window)
//            sample_valid - sample strobe
//            trig_level   - rising-edge trigger threshold
//            in           - upstream VGA timing and colour
//            out          - same fields delayed 2 cycles, trace overlaid
//            triggered    - one-cycle pulse when a capture starts
// Revision : 1.0 - initial release
// ============================================================================
module draw_trace #(
  parameter logic [10:0] TRACE_X0     = 11'd144,
  parameter logic [10:0] TRACE_Y0     = 11'd172,
  parameter logic [11:0] TRACE_COLOR  = 12'h0F0,
  parameter logic [15:0] AUTO_TIMEOUT = 16'd4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic [7:0] trig_level,
  vga_if.in          in,
  vga_if.out         out,
  output logic       triggered
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam logic [8:0]  c_last_addr = 9'd511;
  localparam logic [11:0] c_win_width = 12'd512;

  state_t      r_state, w_state_eff, w_state_nxt;
  logic [15:0] r_auto_cnt, w_auto_cnt_eff, w_auto_cnt_nxt;
  logic [8:0]  r_wr_addr, w_wr_addr_nxt, w_waddr;
  logic [7:0]  r_prev;
  logic        r_vs_prev;
  logic        r_disp_bank, w_disp_bank_nxt;
  logic        w_vs_rise, w_swap, w_trig, w_we;

  // Both banks live in one array; the MSB of the address selects the bank.
  logic [7:0]  r_mem [0:1023];
  logic [7:0]  r_rdata;
  logic [10:0] w_rd_offset;
  logic [8:0]  w_raddr;

  // Stage-1 copies of the upstream fields, aligned with r_rdata.
  logic [10:0] r_s1_hcount, r_s1_vcount;
  logic        r_s1_hsync, r_s1_vsync, r_s1_hblnk, r_s1_vblnk;
  logic [11:0] r_s1_rgb;

  logic        w_in_win, w_hit;
  logic [10:0] w_trace_row;

  assign w_vs_rise = in.vsync & ~r_vs_prev;

  // --------------------------------------------------------------------------
  // Capture FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARMED;
      r_auto_cnt  <= 16'd0;
      r_wr_addr   <= 9'd0;
      r_prev      <= 8'hFF;
      r_vs_prev   <= 1'b0;
      r_disp_bank <= 1'b1;
      triggered   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_auto_cnt  <= w_auto_cnt_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_vs_prev   <= in.vsync;
      r_disp_bank <= w_disp_bank_nxt;
      triggered   <= w_trig;
      if (sample_valid) begin
        r_prev <= sample;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture FSM: next state, write control
  // A swap is resolved first so that a sample arriving in the same cycle is
  // judged as an ARMED sample against the freshly released bank.
  // --------------------------------------------------------------------------
  always_comb begin
    w_swap         = 1'b0;
    w_trig         = 1'b0;
    w_we           = 1'b0;
    w_waddr        = r_wr_addr;
    w_state_eff    = r_state;
    w_auto_cnt_eff = r_auto_cnt;

    if (r_state == FULL && w_vs_rise) begin
      w_swap         = 1'b1;
      w_state_eff    = ARMED;
      w_auto_cnt_eff = 16'd0;
    end

    w_state_nxt    = w_state_eff;
    w_auto_cnt_nxt = w_auto_cnt_eff;
    w_wr_addr_nxt  = r_wr_addr;

    if (sample_valid) begin
      case (w_state_eff)
        ARMED: begin
          // The timeout fires on the sample after AUTO_TIMEOUT untriggered ones.
          if ((r_prev < trig_level && sample >= trig_level) ||
              w_auto_cnt_eff == AUTO_TIMEOUT) begin
            w_trig         = 1'b1;
            w_we           = 1'b1;
            w_waddr        = 9'd0;
            w_wr_addr_nxt  = 9'd1;
            w_auto_cnt_nxt = 16'd0;
            w_state_nxt    = CAPTURE;
          end else begin
            w_auto_cnt_nxt = w_auto_cnt_eff + 16'd1;
          end
        end
        CAPTURE: begin
          w_we = 1'b1;
          if (r_wr_addr == c_last_addr) begin
            w_state_nxt = FULL;
          end else begin
            w_wr_addr_nxt = r_wr_addr + 9'd1;
          end
        end
        default: begin
        end
      endcase
    end

    w_disp_bank_nxt = r_disp_bank ^ w_swap;
  end

  // --------------------------------------------------------------------------
  // Sample storage. Capture always targets the bank not being displayed after
  // any swap in this cycle; the read uses the display bank as it stood.
  // --------------------------------------------------------------------------
  assign w_rd_offset = in.hcount - TRACE_X0;
  assign w_raddr     = w_rd_offset[8:0];

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[{~w_disp_bank_nxt, w_waddr}] <= sample;
    end
    r_rdata <= r_mem[{r_disp_bank, w_raddr}];
  end

  // --------------------------------------------------------------------------
  // Pixel pipeline: stage 1 matches the memory read, stage 2 drives out.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_hcount <= 11'd0;
      r_s1_vcount <= 11'd0;
      r_s1_hsync  <= 1'b0;
      r_s1_vsync  <= 1'b0;
      r_s1_hblnk  <= 1'b0;
      r_s1_vblnk  <= 1'b0;
      r_s1_rgb    <= 12'd0;
    end else begin
      r_s1_hcount <= in.hcount;
      r_s1_vcount <= in.vcount;
      r_s1_hsync  <= in.hsync;
      r_s1_vsync  <= in.vsync;
      r_s1_hblnk  <= in.hblnk;
      r_s1_vblnk  <= in.vblnk;
      r_s1_rgb    <= in.rgb;
    end
  end

  // Window bounds are compared in 12 bits so TRACE_X0+512 cannot overflow.
  assign w_in_win    = ({1'b0, r_s1_hcount} >= {1'b0, TRACE_X0}) &&
                       ({1'b0, r_s1_hcount} <  ({1'b0, TRACE_X0} + c_win_width));
  assign w_trace_row = TRACE_Y0 + 11'd255 - {3'b000, r_rdata};
  assign w_hit       = w_in_win && (r_s1_vcount == w_trace_row) &&
                       !r_s1_hblnk && !r_s1_vblnk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out.hcount <= 11'd0;
      out.vcount <= 11'd0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= 12'd0;
    end else begin
      out.hcount <= r_s1_hcount;
      out.vcount <= r_s1_vcount;
      out.hsync  <= r_s1_hsync;
      out.vsync  <= r_s1_vsync;
      out.hblnk  <= r_s1_hblnk;
      out.vblnk  <= r_s1_vblnk;
      out.rgb    <= w_hit ? TRACE_COLOR : r_s1_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_trace.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_trace
// Purpose  : Self-checking bench for draw_trace. A behavioural model keeps
//            the captured samples in a queue and the displayed trace in an
//            array, and predicts every output cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_trace;

  localparam logic [10:0] X0      = 11'd144;
  localparam logic [10:0] Y0      = 11'd172;
  localparam logic [11:0] COLOR   = 12'h0F0;
  localparam int          X0I     = 144;
  localparam int          Y0I     = 172;
  localparam int          TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = 8'd0;
  logic       sample_valid = 1'b0;
  logic [7:0] trig_level = 8'd0;
  logic       triggered;

  vga_if vin ();
  vga_if vout ();

  draw_trace #(
    .TRACE_X0    (X0),
    .TRACE_Y0    (Y0),
    .TRACE_COLOR (COLOR),
    .AUTO_TIMEOUT(16'(TIMEOUT))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample),
    .sample_valid(sample_valid),
    .trig_level  (trig_level),
    .in          (vin),
    .out         (vout),
    .triggered   (triggered)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [25:0] ctl;
    logic [11:0] rgb;
    bit          rgb_known;
  } exp_t;

  int   m_mode;          // 0 = waiting for trigger, 1 = capturing, 2 = full
  int   m_untrig;        // untriggered samples since arming
  int   m_prev;
  bit   m_prev_vs;
  int   cap_q[$];
  int   disp_img[512];
  bit   disp_known;
  exp_t exp1, exp2;
  bit   exp_trig;

  function automatic void model_reset();
    m_mode     = 0;
    m_untrig   = 0;
    m_prev     = 255;
    m_prev_vs  = 1'b0;
    cap_q.delete();
    disp_known = 1'b0;   // bank contents survive reset but are not tracked
    exp1.ctl = '0; exp1.rgb = '0; exp1.rgb_known = 1'b1;
    exp2 = exp1;
    exp_trig = 1'b0;
  endfunction

  function automatic void model_edge();
    exp_t e;
    int   hc;
    exp2 = exp1;
    hc = int'(vin.hcount);
    e.ctl = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk};
    e.rgb = vin.rgb;
    e.rgb_known = 1'b1;
    if (hc >= X0I && hc < X0I + 512 && !vin.hblnk && !vin.vblnk) begin
      if (!disp_known) e.rgb_known = 1'b0;
      else if (int'(vin.vcount) == Y0I + 255 - disp_img[hc - X0I]) e.rgb = COLOR;
    end
    exp1 = e;

    exp_trig = 1'b0;
    if (m_mode == 2 && vin.vsync && !m_prev_vs) begin
      foreach (disp_img[i]) disp_img[i] = cap_q[i];
      disp_known = 1'b1;
      cap_q.delete();
      m_mode = 0;
      m_untrig = 0;
    end
    m_prev_vs = vin.vsync;
    if (sample_valid) begin
      if (m_mode == 0) begin
        if ((m_prev < int'(trig_level) && int'(sample) >= int'(trig_level)) || m_untrig == TIMEOUT) begin
          exp_trig = 1'b1;
          cap_q.delete();
          cap_q.push_back(int'(sample));
          m_mode = 1;
          m_untrig = 0;
        end else begin
          m_untrig++;
        end
      end else if (m_mode == 1) begin
        cap_q.push_back(int'(sample));
        if (cap_q.size() == 512) m_mode = 2;
      end
      m_prev = int'(sample);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("ctl", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, exp2.ctl);
    if (exp2.rgb_known) check_eq("rgb", vout.rgb, exp2.rgb);
    check_eq("triggered", triggered, exp_trig);
  endtask

  task automatic set_pixel(input int hc, input int vc, input bit hb, input bit vb, input logic [11:0] c);
    vin.hcount = 11'(hc);
    vin.vcount = 11'(vc);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = c;
    vin.hsync  = 1'($urandom_range(0, 1));
  endtask

  // Random pixel, steered onto the displayed trace about half the time.
  task automatic rand_pixel();
    int hc, vc;
    hc = $urandom_range(X0I - 10, X0I + 521);
    if (disp_known && hc >= X0I && hc < X0I + 512 && $urandom_range(0, 1) == 1)
      vc = Y0I + 255 - disp_img[hc - X0I];
    else
      vc = $urandom_range(160, 440);
    set_pixel(hc, vc, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 12'($urandom));
  endtask

  task automatic feed(input int s);
    sample = 8'(s);
    sample_valid = 1'b1;
    rand_pixel();
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic vsync_pulse();
    sample_valid = 1'b0;
    vin.vsync = 1'b1;
    rand_pixel();
    tick();
    vin.vsync = 1'b0;
    tick();
  endtask

  task automatic apply_reset(input int cycles);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk,
                           vout.vblnk, vout.rgb, triggered}, 64'd0);
    model_reset();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk,
                            vout.vblnk, vout.rgb, triggered}, 64'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int hits;
    int trig_at;

    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hABC;
    model_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("reset_out", {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk,
                             vout.vblnk, vout.rgb}, 64'd0);
      check_eq("reset_trig", triggered, 1'b0);
    end
    rst = 1'b0;

    // Level trigger on the 140 sample, then a ramp fills the bank.
    trig_level = 8'd128;
    feed(100);
    feed(140);
    check_eq("v1_trig", triggered, 1'b1);
    for (int k = 1; k < 512; k++) begin
      feed((140 + k) % 256);
      if ($urandom_range(0, 3) == 0) begin rand_pixel(); tick(); end
    end
    set_pixel(0, 0, 1'b0, 1'b0, 12'h00F);
    vsync_pulse();

    // Scan the whole window along the expected trace.
    hits = 0;
    for (int k = 0; k < 514; k++) begin
      if (k < 512) set_pixel(X0I + k, Y0I + 255 - ((140 + k) % 256), 1'b0, 1'b0, 12'h00F);
      else         set_pixel(0, 0, 1'b0, 1'b0, 12'h00F);
      tick();
      if (vout.rgb == COLOR) hits++;
    end
    check_eq("v3_hits", hits, 512);

    // vsync in the middle of a capture must not swap.
    trig_level = 8'd128;
    feed(10);
    feed(200);
    check_eq("v4_trig", triggered, 1'b1);
    for (int k = 1; k < 300; k++) feed($urandom_range(0, 255));
    vsync_pulse();
    for (int k = 0; k < 40; k++) begin rand_pixel(); tick(); end
    for (int k = 300; k < 512; k++) feed($urandom_range(0, 255));
    vsync_pulse();

    // Auto-trigger on the sample after TIMEOUT untriggered ones.
    trig_level = 8'd200;
    trig_at = 0;
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      feed(50);
      if (triggered) trig_at = i;
    end
    check_eq("v2_trig_at", trig_at, TIMEOUT + 1);

    // Reset in the middle of a capture, then restart cleanly.
    for (int k = 0; k < 100; k++) feed($urandom_range(0, 255));
    apply_reset(2);
    trig_level = 8'd128;
    feed(100);
    feed(140);
    check_eq("v6_trig", triggered, 1'b1);
    for (int k = 1; k < 512; k++) feed($urandom_range(0, 255));
    vsync_pulse();
    for (int k = 0; k < 200; k++) begin rand_pixel(); tick(); end

    // Random traffic with swaps, level changes and occasional resets.
    for (int n = 0; n < 15000; n++) begin
      if ($urandom_range(0, 63) == 0) vin.vsync = ~vin.vsync;
      if ($urandom_range(0, 255) == 0) trig_level = 8'($urandom);
      sample = 8'($urandom);
      sample_valid = ($urandom_range(0, 1) == 1);
      rand_pixel();
      tick();
      if ($urandom_range(0, 3999) == 0) apply_reset($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
